// File: rtl/fb_adder_bist.sv
// -----------------------------------------------------------------------------
// fb_adder_bist
//   Built-in self-test engine for the 4-bit ripple adder fb_adder. Walks all
//   512 {cin, a, b} vectors in ascending order (b in the LSBs), waits
//   SETTLE_CYCLES after each new vector, then compares {cout, s} with the
//   internally computed a + b + cin. Reports pass/fail, a saturating error
//   count and the index of the first failing vector.
//
//   Optional build macro: FB_ADDER_BIST_STOP_ON_FAIL_EN
//     When defined, the run stops at the first mismatch and the failing
//     vector is left on a/b/cin for debug.
//
// Parameters
//   SETTLE_CYCLES  cycles between operand update and response sampling (1..15)
//   ERR_W          width of the saturating error counter
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   single-cycle pulse; starts a run from IDLE or DONE
//   s           in   sum from the adder under test
//   cout        in   carry-out from the adder under test
//   a, b, cin   out  registered operands driven into the adder
//   busy        out  high while a run is in progress
//   done        out  high once a run completes, held until the next start
//   pass        out  valid with done; 1 when no mismatch was counted
//   err_cnt     out  number of mismatching vectors, saturating at all-ones
//   first_fail  out  {cin,a,b} index of the first mismatch, 0 if none
// -----------------------------------------------------------------------------
module fb_adder_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       s,
  input  logic             cout,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic             cin,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [8:0]       first_fail
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [8:0]       LAST_IDX  = 9'd511;

  logic [2:0]       state_q, state_d;
  logic [8:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [8:0]       vec_q, vec_d;     // {cin, a, b} as presented to the adder
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [8:0]       first_q, first_d;

  logic [4:0] expected;
  logic       mismatch;

  // Expected value comes from the registered operands, so the compare is
  // always against the vector that has been settling on the adder inputs.
  assign expected = {1'b0, vec_q[7:4]} + {1'b0, vec_q[3:0]} + {4'b0000, vec_q[8]};
  assign mismatch = ({cout, s} != expected);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          done_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        vec_d   = idx_q;
        cnt_d   = SETTLE_LD;
        state_d = ST_WAIT;
      end

      // Leaving on a count of 1 makes WAIT last exactly SETTLE_CYCLES cycles.
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
          if (err_q == '0)      first_d = idx_q;
        end
`ifdef FB_ADDER_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else
`endif
        if (idx_q == LAST_IDX) begin
          // pass is taken from the updated count so a failure on the last
          // vector is reflected.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign cin        = vec_q[8];
  assign a          = vec_q[7:4];
  assign b          = vec_q[3:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_fb_adder_bist.sv
// -----------------------------------------------------------------------------
// tb_fb_adder_bist
//   Bench for fb_adder_bist. Two engines share clock and reset:
//     u1: SETTLE_CYCLES=1, ERR_W=10
//     u3: SETTLE_CYCLES=3, ERR_W=4 (small counter exposes saturation)
//   Each engine drives a behavioural adder with an injectable fault. The
//   expected outcome of a run is derived by sweeping all 512 vectors through
//   the same faulty adder and counting disagreements with a + b + cin.
// -----------------------------------------------------------------------------
module tb_fb_adder_bist;

`ifdef FB_ADDER_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  // kind: 0 none, 1 output bit pos stuck at val, 2 xor mask on vector vec
  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] pos;
    logic       val;
    logic [8:0] vec;
    logic [4:0] mask;
  } fault_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int     sel = 0;
  logic   go  = 1'b0;
  fault_t f1  = '0;
  fault_t f3  = '0;

  logic       start1, start3;
  logic [3:0] a1, b1, s1, a3, b3, s3;
  logic       cin1, cout1, busy1, done1, pass1;
  logic       cin3, cout3, busy3, done3, pass3;
  logic [9:0] err1;
  logic [3:0] err3;
  logic [8:0] first1, first3;

  assign start1 = go && (sel == 0);
  assign start3 = go && (sel == 1);

  function automatic logic [4:0] faulty_adder(input fault_t f, input logic [8:0] v);
    int r;
    logic [4:0] o;
    r = int'(v[8]) + int'(v[7:4]) + int'(v[3:0]);
    o = 5'(r);
    if (f.kind == 2'd1) o[f.pos] = f.val;
    else if (f.kind == 2'd2 && v == f.vec) o = o ^ f.mask;
    return o;
  endfunction

  always_comb {cout1, s1} = faulty_adder(f1, {cin1, a1, b1});
  always_comb {cout3, s3} = faulty_adder(f3, {cin3, a3, b3});

  fb_adder_bist #(.SETTLE_CYCLES(1), .ERR_W(10)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s(s1), .cout(cout1),
    .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(first1)
  );

  fb_adder_bist #(.SETTLE_CYCLES(3), .ERR_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s(s3), .cout(cout3),
    .a(a3), .b(b3), .cin(cin3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_fail(first3)
  );

  // Outputs of whichever engine is under test.
  logic       o_busy, o_done, o_pass;
  logic [9:0] o_err;
  logic [8:0] o_first, o_vec;
  always_comb begin
    if (sel == 0) begin
      o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = err1; o_first = first1; o_vec = {cin1, a1, b1};
    end else begin
      o_busy = busy3; o_done = done3; o_pass = pass3;
      o_err = {6'd0, err3}; o_first = first3; o_vec = {cin3, a3, b3};
    end
  end

  // Reference: sweep all vectors in order, count disagreements with the
  // arithmetic sum, saturate at the counter width, stop early if configured.
  task automatic model_run(input fault_t f, input int err_w, output int e,
                           output int first, output int last, output bit p);
    bit found;
    int want;
    logic [8:0] vv;
    e = 0; first = 0; last = 511; found = 1'b0;
    for (int v = 0; v < 512; v++) begin
      vv   = 9'(v);
      want = int'(vv[8]) + int'(vv[7:4]) + int'(vv[3:0]);
      if (int'(faulty_adder(f, vv)) != want) begin
        if (!found) first = v;
        found = 1'b1;
        if (e < (1 << err_w) - 1) e++;
        if (STOP) begin
          last = v;
          break;
        end
      end
    end
    p = !found;
  endtask

  // Runs one complete self-test on the selected engine and checks the result.
  // restart_at > 0 pulses start again that many cycles into the run.
  task automatic run_bist(input int inst, input fault_t f, input int settle,
                          input int err_w, input int restart_at, input string tag);
    int exp_err, exp_first, exp_last, exp_cyc, cycles, lim;
    bit exp_pass, hit;
    model_run(f, err_w, exp_err, exp_first, exp_last, exp_pass);
    exp_cyc = (exp_last + 1) * (2 + settle);
    lim     = exp_cyc + 20;
    sel = inst;
    if (inst == 0) f1 = f; else f3 = f;

    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after_start: got busy=%0b done=%0b want busy=1 done=0", tag, o_busy, o_done);
    end

    cycles = 0; hit = 1'b0;
    while (!hit && cycles < lim) begin
      @(posedge clk); #1;
      cycles++;
      go = (cycles == restart_at);
      if (o_done === 1'b1) hit = 1'b1;
    end
    go = 1'b0;

    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s done_timeout: got no done in %0d cycles want done at %0d", tag, lim, exp_cyc);
      return;
    end
    if (cycles != exp_cyc) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, cycles, exp_cyc);
    end
    total++;
    if (o_err !== 10'(exp_err)) begin
      bad++;
      $display("FAIL %s err_cnt: got %0d want %0d", tag, o_err, exp_err);
    end
    total++;
    if (o_first !== 9'(exp_first)) begin
      bad++;
      $display("FAIL %s first_fail: got %h want %h", tag, o_first, 9'(exp_first));
    end
    total++;
    if (o_pass !== exp_pass || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s pass_busy: got pass=%0b busy=%0b want pass=%0b busy=0", tag, o_pass, o_busy, exp_pass);
    end
    total++;
    if (o_vec !== 9'(exp_last)) begin
      bad++;
      $display("FAIL %s final_vector: got %h want %h", tag, o_vec, 9'(exp_last));
    end

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_done !== 1'b1 || o_err !== 10'(exp_err)) begin
      bad++;
      $display("FAIL %s done_hold: got done=%0b err=%0d want done=1 err=%0d", tag, o_done, o_err, exp_err);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy1, done1, pass1, err1, first1, cin1, a1, b1} !== '0 ||
        {busy3, done3, pass3, err3, first3, cin3, a3, b3} !== '0) begin
      bad++;
      $display("FAIL reset_values: got u1=%h u3=%h want 0",
               {busy1, done1, pass1, err1, first1, cin1, a1, b1},
               {busy3, done3, pass3, err3, first3, cin3, a3, b3});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b want 0 0", busy1, done1);
    end
  endtask

  task automatic test_correct();
    run_bist(0, fault_t'('0), 1, 10, 0, "correct_s1");
  endtask

  task automatic test_stuck_faults();
    fault_t f;
    f = '0; f.kind = 2'd1; f.pos = 3'd0; f.val = 1'b0;
    run_bist(0, f, 1, 10, 0, "s0_stuck0");
    f = '0; f.kind = 2'd1; f.pos = 3'd4; f.val = 1'b0;
    run_bist(0, f, 1, 10, 0, "cout_stuck0");
  endtask

  task automatic test_random();
    fault_t f;
    for (int i = 0; i < 4; i++) begin
      f = '0;
      if ($urandom_range(0, 1) == 0) begin
        f.kind = 2'd1;
        f.pos  = 3'($urandom_range(0, 4));
        f.val  = 1'($urandom_range(0, 1));
      end else begin
        f.kind = 2'd2;
        f.vec  = 9'($urandom_range(0, 511));
        f.mask = 5'($urandom_range(1, 31));
      end
      run_bist(0, f, 1, 10, 0, "random_fault");
    end
  endtask

  task automatic test_restart_ignored();
    run_bist(0, fault_t'('0), 1, 10, 100, "restart_ignored");
  endtask

  task automatic test_midrun_reset();
    sel = 0; f1 = '0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    repeat (700) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({cin1, a1, b1} !== 9'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset_ctrl: got vec=%h busy=%0b done=%0b want 0 0 0", {cin1, a1, b1}, busy1, done1);
    end
    total++;
    if (pass1 !== 1'b0 || err1 !== 10'd0 || first1 !== 9'd0) begin
      bad++;
      $display("FAIL midrun_reset_result: got pass=%0b err=%0d first=%h want 0 0 0", pass1, err1, first1);
    end
    #2 rst_n = 1'b1;
    run_bist(0, fault_t'('0), 1, 10, 0, "after_reset");
  endtask

  task automatic test_settle3();
    fault_t f;
    run_bist(1, fault_t'('0), 3, 4, 0, "correct_s3");
    f = '0; f.kind = 2'd1; f.pos = 3'd0; f.val = 1'b0;
    run_bist(1, f, 3, 4, 0, "s3_saturate");
  endtask

  initial begin
    test_reset();
    test_correct();
    test_stuck_faults();
    test_random();
    test_restart_ignored();
    test_midrun_reset();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
